// File: rtl/fifo_burst_drain.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_burst_drain
//  Purpose  : Drains an async FIFO read port into a valid/ready stream.
//             The FIFO's one-cycle read latency is hidden behind a 3-entry
//             skid buffer. A last flag marks every BURST_LEN-th beat, and a
//             running count of accepted beats is kept.
//  Ports    : clk, rst         read-domain clock, async active-high reset
//             en               drain enable
//             rd_en            FIFO read request (out)
//             rd_data          FIFO read data, valid the cycle after rd_en
//             rd_empty         FIFO empty flag
//             m_valid/m_ready  output stream handshake
//             m_data, m_last   output beat data and end-of-burst flag
//             busy             read in flight or buffer non-empty
//             word_count       total beats accepted downstream
//  Revision : 1.0  initial release
// ============================================================================
module fifo_burst_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int              BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] r_mem [3];
  logic [1:0]            r_head;
  logic [1:0]            r_tail;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic [CNT_WIDTH-1:0]  r_word_count;

  logic [2:0]            w_fill;
  logic                  w_push;
  logic                  w_pop;

  // Pointer increment for a 3-deep ring: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] f_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for the in-flight word so a capture can never overflow.
  // Only registered state feeds this, so m_ready has no path to rd_en.
  assign w_fill = {1'b0, r_occ} + {2'b00, r_inflight};
  assign rd_en  = !rst && en && !rd_empty && (w_fill < 3'd3);

  assign w_push = r_inflight;
  assign w_pop  = m_valid && m_ready;

  assign m_valid    = (r_occ != 2'd0);
  assign m_data     = r_mem[r_head];
  assign m_last     = m_valid && (r_beat_cnt == c_last_beat);
  assign busy       = r_inflight || (r_occ != 2'd0);
  assign word_count = r_word_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_mem[i] <= '0;
      end
      r_head       <= 2'd0;
      r_tail       <= 2'd0;
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_beat_cnt   <= '0;
      r_word_count <= '0;
    end else begin
      r_inflight <= rd_en;

      if (w_push) begin
        r_mem[r_tail] <= rd_data;
        r_tail        <= f_next(r_tail);
      end

      if (w_pop) begin
        r_head       <= f_next(r_head);
        r_word_count <= r_word_count + 1'b1;
        // Burst position advances only on accepted beats, so it survives
        // empty gaps, backpressure and enable drops.
        if (r_beat_cnt == c_last_beat) begin
          r_beat_cnt <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end

      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_burst_drain
//  Purpose  : Self-checking bench for fifo_burst_drain. A queue-based FIFO
//             model feeds two instances (BURST_LEN=16/CNT_WIDTH=32 and
//             BURST_LEN=1/CNT_WIDTH=4); a stream-level reference model checks
//             every cycle, alongside a cycle table and directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_burst_drain;

  localparam int BL = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] rd_data = '0;
  logic        rd_empty = 1'b1;

  logic        rd_en, m_valid, m_last, busy;
  logic [31:0] m_data, word_count;
  logic        rd_en1, m_valid1, m_last1, busy1;
  logic [31:0] m_data1;
  logic [3:0]  wc1;

  fifo_burst_drain #(.DATA_WIDTH(32), .BURST_LEN(BL), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .word_count(word_count)
  );

  fifo_burst_drain #(.DATA_WIDTH(32), .BURST_LEN(1), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .rd_en(rd_en1), .rd_data(rd_data),
    .rd_empty(rd_empty), .m_valid(m_valid1), .m_ready(m_ready),
    .m_data(m_data1), .m_last(m_last1), .busy(busy1), .word_count(wc1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model and reference state ----------------
  logic [31:0] fifo_q[$];   // words still in the FIFO
  logic [31:0] exp_q[$];    // words read from the FIFO, not yet accepted
  logic        last_rd = 1'b0;
  int          n_rd = 0, first_rd = 0, cyc = 0;
  int          beats = 0, n_acc = 0, first_acc = 0, last_acc = 0;
  int          n_last_dut = 0, n_last1 = 0;
  logic [31:0] last_data_dut = '0;
  logic [31:0] model_wc = '0;

  always @(posedge clk) begin
    last_rd = 1'b0;
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en && fifo_q.size() > 0) begin
      rd_data <= fifo_q[0];
      exp_q.push_back(fifo_q.pop_front());
      last_rd = 1'b1;
      if (n_rd == 0) first_rd = cyc;
      n_rd++;
    end
    rd_empty <= (fifo_q.size() == 0);
    cyc++;
  end

  // Reference checks, taken mid-cycle when every signal is settled.
  always @(negedge clk) begin : mon
    logic ev;
    if (!rst) begin
      ev = (exp_q.size() > (last_rd ? 1 : 0));
      chk("rd_en", rd_en, en && !rd_empty && (exp_q.size() < 3));
      chk("occupancy_le_3", exp_q.size() <= 3, 1);
      chk("busy", busy, exp_q.size() != 0);
      chk("m_valid", m_valid, ev);
      chk("m_last", m_last, ev && (beats % BL == BL - 1));
      chk("word_count", word_count, model_wc);
      chk("u1_rd_en", rd_en1, en && !rd_empty && (exp_q.size() < 3));
      chk("u1_m_valid", m_valid1, ev);
      chk("u1_m_last", m_last1, ev);
      chk("u1_word_count", wc1, model_wc[3:0]);
      if (ev) begin
        chk("m_data", m_data, exp_q[0]);
        chk("u1_m_data", m_data1, exp_q[0]);
      end
      if (m_valid && m_ready) begin
        if (n_acc == 0) first_acc = cyc;
        last_acc = cyc;
        n_acc++;
        if (m_last) begin
          n_last_dut++;
          last_data_dut = m_data;
        end
      end
      if (m_valid1 && m_ready && m_last1) n_last1++;
      if (ev && m_ready) begin
        void'(exp_q.pop_front());
        beats++;
        model_wc++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic rst_assert();
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    n_rd = 0; beats = 0; n_acc = 0; n_last_dut = 0; n_last1 = 0;
    model_wc = '0;
  endtask

  task automatic push(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
  endtask

  task automatic start_test(input logic [31:0] base, input int n);
    rst_assert();
    push(base, n);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_wc(input string name, input logic [31:0] n, input int budget);
    int k = 0;
    while (word_count != n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, word_count, n);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic        x_rd;
    logic        x_v;
    logic [31:0] x_d;
    logic        x_busy;
    logic [31:0] x_wc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // Cycle 0 is the first cycle out of reset with three words preloaded.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0000, 1'b1, 32'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 32'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 32'd1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_0002, 1'b1, 32'd2};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd3};

    // Reset state
    rst_assert();
    cycles(2);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_last", m_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_word_count", word_count, 0);

    // Cycle table
    push(32'hA5A5_0000, 3);
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      en = tbl[i].en;
      m_ready = tbl[i].rdy;
      if (i == 0) rst = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_rd_en", i), rd_en, tbl[i].x_rd);
      chk($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].x_v);
      if (tbl[i].x_v) chk($sformatf("tbl%0d_m_data", i), m_data, tbl[i].x_d);
      chk($sformatf("tbl%0d_m_last", i), m_last, 0);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].x_busy);
      chk($sformatf("tbl%0d_word_count", i), word_count, tbl[i].x_wc);
    end

    // 1. Basic drain
    en = 1'b1; m_ready = 1'b1;
    start_test(0, 32);
    wait_wc("t1_wc", 32, 100);
    chk("t1_latency", first_acc - first_rd, 2);
    chk("t1_throughput", last_acc - first_acc, 31);
    chk("t1_last_count", n_last_dut, 2);
    cycles(2);
    chk("t1_busy_after", busy, 0);

    // 2. Backpressure
    m_ready = 1'b0;
    start_test(0, 32);
    cycles(10);
    chk("t2_rd_pulses", n_rd, 3);
    @(negedge clk);
    chk("t2_held_valid", m_valid, 1);
    chk("t2_held_data", m_data, 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_wc("t2_wc", 32, 100);

    // 3. Toggling ready
    start_test(0, 48);
    for (int i = 0; i < 200 && word_count != 48; i++) begin
      @(posedge clk); #1;
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("t3_wc", word_count, 48);
    chk("t3_last_count", n_last_dut, 3);

    // 4. Empty gap
    start_test(0, 6);
    wait_wc("t4_wc6", 6, 50);
    cycles(20);
    @(negedge clk);
    chk("t4_gap_valid", m_valid, 0);
    chk("t4_gap_last_count", n_last_dut, 0);
    @(posedge clk); #1;
    push(6, 10);
    wait_wc("t4_wc16", 16, 80);
    chk("t4_last_count", n_last_dut, 1);
    chk("t4_last_data", last_data_dut, 15);

    // 5. Enable drop after the read of word 7
    start_test(0, 32);
    for (int k = 0; k < 50 && n_rd < 8; k++) begin
      @(posedge clk); #1;
    end
    en = 1'b0;
    cycles(10);
    @(negedge clk);
    chk("t5_reads", n_rd, 8);
    chk("t5_busy", busy, 0);
    chk("t5_wc", word_count, 8);
    @(posedge clk); #1;
    en = 1'b1;
    wait_wc("t5_wc32", 32, 100);
    chk("t5_last_count", n_last_dut, 2);

    // 6. Reset mid-burst, asynchronous to clk
    start_test(0, 32);
    wait_wc("t6_wc10", 10, 50);
    #2;
    rst_assert();
    #1;
    chk("t6_m_valid", m_valid, 0);
    chk("t6_rd_en", rd_en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_word_count", word_count, 0);
    chk("t6_u1_word_count", wc1, 0);
    @(posedge clk); #1;
    push(32'h100, 32);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_wc("t6_wc32", 32, 100);
    chk("t6_last_count", n_last_dut, 2);
    chk("t6_u1_last_count", n_last1, 32);

    // Randomized traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      en = ($urandom % 4) != 0;
      m_ready = ($urandom % 3) != 0;
      if ($urandom % 3 == 0) push($urandom, 1 + int'($urandom % 3));
      if ($urandom % 250 == 0) begin
        #2;
        rst_assert();
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
    en = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 300 && (busy || fifo_q.size() != 0); k++) @(negedge clk);
    @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_fifo", fifo_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Downstream consumer of the async FIFO's read port. It runs in the read clock domain and pulls words through the FIFO's `rd_en` / `rd_data` / `rd_empty` interface.
- It hides the FIFO's one-cycle read latency behind a 3-entry skid buffer.
- It re-emits the words as a valid/ready stream, with a `last` flag every BURST_LEN beats.
- It keeps a running beat count for the bench and for the system.

Parameters:
- DATA_WIDTH, 32, width of each FIFO word and stream beat.
- BURST_LEN, 16, beats per burst; must be >= 1. With 1, every beat is last.
- CNT_WIDTH, 32, width of `word_count`.

Ports:
- clk  in  1  read-domain clock (FIFO `rd_clk`).
- rst  in  1  asynchronous, active-high reset.
- en  in  1  drain enable.
- rd_en  out  1  FIFO read request.
- rd_data  in  DATA_WIDTH  FIFO read data. Valid the cycle after an accepted `rd_en`.
- rd_empty  in  1  FIFO empty flag.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  output beat data.
- m_last  out  1  final beat of the current burst.
- busy  out  1  read in flight or buffer non-empty.
- word_count  out  CNT_WIDTH  total beats accepted downstream.

Behaviour:
- Reset: asserting `rst` forces the following immediately, independent of `clk`:
  - buffer occupancy = 0, inflight = 0, beat_cnt = 0, word_count = 0;
  - m_valid = 0, m_last = 0, busy = 0, rd_en = 0;
  - m_data = 0 (the buffer contents are cleared).
- Read issue:
  - `rd_en = !rst && en && !rd_empty && (occupancy + inflight < 3)`.
  - The function uses registered state only, so there is no combinational path from `m_ready` to `rd_en`.
- In-flight tracking:
  - inflight is a register that takes the value `rd_en` at each posedge.
  - While inflight = 1, `rd_data` is written into the buffer tail at the next posedge.
- Buffer:
  - 3-entry circular buffer with 2-bit head and tail pointers that wrap 2 -> 0.
  - Push = inflight. Pop = `m_valid && m_ready`.
  - A simultaneous push and pop leaves occupancy unchanged.
  - Overflow is impossible by construction. The bench asserts occupancy <= 3.
- Output:
  - `m_valid = (occupancy != 0)`; `m_data` = head entry.
  - `m_data` and `m_last` hold stable while `m_valid && !m_ready`.
- Latency: `rd_en` high in cycle N gives a capture at the end of cycle N+1, so the earliest `m_valid` is cycle N+2.
- Throughput: with `en = 1`, the FIFO never empty and `m_ready` held high, the block sustains 1 beat per cycle after the initial latency.
- Burst counter:
  - beat_cnt has width clog2(BURST_LEN), minimum 1.
  - `m_last = m_valid && (beat_cnt == BURST_LEN-1)`.
  - On each pop, beat_cnt increments, wrapping to 0 after the last beat.
  - beat_cnt holds across FIFO-empty gaps, backpressure and `en` deassertion. Bursts are counted in beats, not in time.
- word_count increments on each pop and wraps modulo 2^CNT_WIDTH.
- busy = inflight || (occupancy != 0).
- `en` falling:
  - no new `rd_en` from that cycle on;
  - an in-flight word is still captured;
  - the buffer continues to drain normally.
- `rd_empty` rising mid-burst: reads stop, buffered beats drain, m_valid falls when the buffer is empty, and beat_cnt is retained.
- Reset mid-operation: any in-flight word and all buffered words are discarded. This loss is accepted. The FIFO reset is expected to accompany it.

Test Plan:
1. Basic drain:
   - Stimulus: reset, preload FIFO with 0..31, en = 1, m_ready = 1.
   - Response: m_data = 0..31 on consecutive cycles starting 2 cycles after the first rd_en; m_last high on beats 15 and 31 only; word_count = 32; busy low afterwards.
2. Backpressure:
   - Stimulus: FIFO holds 0..31, m_ready = 0 for 10 cycles.
   - Response: exactly 3 rd_en pulses, then rd_en = 0; m_valid = 1 with m_data = 0 held stable.
   - Then release m_ready: 0..31 arrive in order with no loss or duplication.
3. Toggling ready:
   - Stimulus: m_ready alternates 1/0 each cycle over 48 words.
   - Response: output sequence matches input exactly; m_last on beats 15, 31 and 47; word_count = 48.
4. Empty gap:
   - Stimulus: write 0..5, wait 20 cycles, write 6..15.
   - Response: m_valid low during the gap; beat_cnt holds at 6; m_last asserted only with m_data = 15.
5. Enable drop:
   - Stimulus: en deasserted the cycle after rd_en for word 7.
   - Response: word 7 is still captured and emitted; no further rd_en; busy falls after the buffer drains.
   - Then en = 1: the stream resumes at word 8 with burst alignment kept.
6. Reset mid-burst:
   - Stimulus: rst pulse after beat 9, asynchronous to clk.
   - Response: m_valid, rd_en, busy and word_count are 0 immediately.
   - After reset is released with a fresh FIFO: m_last on the 16th post-reset beat. With BURST_LEN = 1, m_last is high on every beat.
